// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI read arbiter: round-robin grant of a shared AR/R channel,
// one outstanding burst, with beat counting and sticky protocol-error flag.
module axi_rd_arbiter #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                          CLK,
  input  logic                          RSTN,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] S0_ARADDR,
  input  logic [7:0]                    S0_ARLEN,
  input  logic                          S0_ARVALID,
  output logic                          S0_ARREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] S0_RDATA,
  output logic [1:0]                    S0_RRESP,
  output logic                          S0_RLAST,
  output logic                          S0_RVALID,
  input  logic                          S0_RREADY,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] S1_ARADDR,
  input  logic [7:0]                    S1_ARLEN,
  input  logic                          S1_ARVALID,
  output logic                          S1_ARREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] S1_RDATA,
  output logic [1:0]                    S1_RRESP,
  output logic                          S1_RLAST,
  output logic                          S1_RVALID,
  input  logic                          S1_RREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]                    M_AXI_ARLEN,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  output logic                          M_AXI_ARID,
  output logic [2:0]                    M_AXI_ARSIZE,
  output logic [1:0]                    M_AXI_ARBURST,
  output logic [1:0]                    M_AXI_ARLOCK,
  output logic [3:0]                    M_AXI_ARCACHE,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic [3:0]                    M_AXI_ARQOS,
  output logic                          M_AXI_ARUSER,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,
  output logic                          GRANT,
  output logic                          BUSY,
  output logic                          ERR
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                          state, state_nxt;
  logic                            grant, grant_nxt;
  logic                            last_grant, last_grant_nxt;
  logic                            arvalid, arvalid_nxt;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   araddr, araddr_nxt;
  logic [7:0]                      arlen, arlen_nxt;
  logic [7:0]                      beat_cnt, beat_cnt_nxt;
  logic                            busy, busy_nxt;
  logic                            err, err_nxt;
  logic                            winner;
  logic                            r_ready;
  logic                            r_hs;

  // Fixed AR sideband: single ID, 32-bit beats, INCR, normal access
  assign M_AXI_ARID    = 1'b0;
  assign M_AXI_ARSIZE  = 3'b010;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARLOCK  = 2'b00;
  assign M_AXI_ARCACHE = 4'b0011;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARQOS   = 4'b0000;
  assign M_AXI_ARUSER  = 1'b0;

  assign M_AXI_ARADDR  = araddr;
  assign M_AXI_ARLEN   = arlen;
  assign M_AXI_ARVALID = arvalid;
  assign GRANT         = grant;
  assign BUSY          = busy;
  assign ERR           = err;

  // Handshake steering follows the current owner; data/resp/last fan out to both
  assign S0_ARREADY = (state == ADDR) && M_AXI_ARREADY && !grant;
  assign S1_ARREADY = (state == ADDR) && M_AXI_ARREADY &&  grant;
  assign r_ready    = (state == DATA) && (grant ? S1_RREADY : S0_RREADY);
  assign M_AXI_RREADY = r_ready;
  assign S0_RVALID  = (state == DATA) && M_AXI_RVALID && !grant;
  assign S1_RVALID  = (state == DATA) && M_AXI_RVALID &&  grant;
  assign S0_RDATA   = M_AXI_RDATA;
  assign S1_RDATA   = M_AXI_RDATA;
  assign S0_RRESP   = M_AXI_RRESP;
  assign S1_RRESP   = M_AXI_RRESP;
  assign S0_RLAST   = M_AXI_RLAST;
  assign S1_RLAST   = M_AXI_RLAST;

  assign r_hs   = (state == DATA) && M_AXI_RVALID && r_ready;
  // On contention the requester not served last time wins
  assign winner = (S0_ARVALID && S1_ARVALID) ? !last_grant : S1_ARVALID;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      arvalid    <= 1'b0;
      araddr     <= '0;
      arlen      <= 8'd0;
      beat_cnt   <= 8'd0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      arvalid    <= arvalid_nxt;
      araddr     <= araddr_nxt;
      arlen      <= arlen_nxt;
      beat_cnt   <= beat_cnt_nxt;
      busy       <= busy_nxt;
      err        <= err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    arvalid_nxt    = arvalid;
    araddr_nxt     = araddr;
    arlen_nxt      = arlen;
    beat_cnt_nxt   = beat_cnt;
    err_nxt        = err;

    case (state)
      IDLE: begin
        if (M_AXI_RVALID) err_nxt = 1'b1;
        if (S0_ARVALID || S1_ARVALID) begin
          grant_nxt   = winner;
          araddr_nxt  = winner ? S1_ARADDR : S0_ARADDR;
          arlen_nxt   = winner ? S1_ARLEN  : S0_ARLEN;
          arvalid_nxt = 1'b1;
          state_nxt   = ADDR;
        end
      end
      ADDR: begin
        if (M_AXI_RVALID) err_nxt = 1'b1;
        if (M_AXI_ARREADY) begin
          arvalid_nxt    = 1'b0;
          beat_cnt_nxt   = 8'd0;
          last_grant_nxt = grant;
          state_nxt      = DATA;
        end
      end
      DATA: begin
        if (r_hs) begin
          beat_cnt_nxt = beat_cnt + 8'd1;
          // beat_cnt holds the index of the beat being accepted
          if (M_AXI_RLAST) begin
            state_nxt = IDLE;
            if (beat_cnt != arlen) err_nxt = 1'b1;
          end else if (beat_cnt == arlen) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: directed bursts, a behavioural AXI slave,
// and a monitor that checks every AR/R handshake against queued expectations.
module tb_axi_rd_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          CLK, RSTN;
  logic [AW-1:0] S0_ARADDR, S1_ARADDR;
  logic [7:0]    S0_ARLEN, S1_ARLEN;
  logic          S0_ARVALID, S1_ARVALID, S0_ARREADY, S1_ARREADY;
  logic [DW-1:0] S0_RDATA, S1_RDATA;
  logic [1:0]    S0_RRESP, S1_RRESP;
  logic          S0_RLAST, S1_RLAST, S0_RVALID, S1_RVALID, S0_RREADY, S1_RREADY;
  logic [AW-1:0] M_AXI_ARADDR;
  logic [7:0]    M_AXI_ARLEN;
  logic          M_AXI_ARVALID, M_AXI_ARREADY, M_AXI_ARID, M_AXI_ARUSER;
  logic [2:0]    M_AXI_ARSIZE, M_AXI_ARPROT;
  logic [1:0]    M_AXI_ARBURST, M_AXI_ARLOCK;
  logic [3:0]    M_AXI_ARCACHE, M_AXI_ARQOS;
  logic [DW-1:0] M_AXI_RDATA;
  logic [1:0]    M_AXI_RRESP;
  logic          M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;
  logic          GRANT, BUSY, ERR;

  axi_rd_arbiter #(.C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .S0_ARADDR(S0_ARADDR), .S0_ARLEN(S0_ARLEN), .S0_ARVALID(S0_ARVALID), .S0_ARREADY(S0_ARREADY),
    .S0_RDATA(S0_RDATA), .S0_RRESP(S0_RRESP), .S0_RLAST(S0_RLAST), .S0_RVALID(S0_RVALID), .S0_RREADY(S0_RREADY),
    .S1_ARADDR(S1_ARADDR), .S1_ARLEN(S1_ARLEN), .S1_ARVALID(S1_ARVALID), .S1_ARREADY(S1_ARREADY),
    .S1_RDATA(S1_RDATA), .S1_RRESP(S1_RRESP), .S1_RLAST(S1_RLAST), .S1_RVALID(S1_RVALID), .S1_RREADY(S1_RREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARSIZE(M_AXI_ARSIZE),
    .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARLOCK(M_AXI_ARLOCK), .M_AXI_ARCACHE(M_AXI_ARCACHE),
    .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARQOS(M_AXI_ARQOS), .M_AXI_ARUSER(M_AXI_ARUSER),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
    .GRANT(GRANT), .BUSY(BUSY), .ERR(ERR)
  );

  typedef struct packed { logic n; logic [AW-1:0] addr; logic [7:0] len; } ar_exp_t;
  typedef struct packed { logic n; logic [DW-1:0] data; logic [1:0] resp; logic last; } r_exp_t;

  ar_exp_t ar_q[$];
  r_exp_t  r_q[$];
  int checks = 0;
  int failures = 0;
  int beats_seen = 0;

  // Slave behaviour knobs
  int ar_stall = 0;
  int early_last = -1;
  bit omit_last = 0;
  bit inject = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got timeout/unexpected event expected handshake", name);
  endfunction

  function automatic void check_beat(input bit n, input logic [DW-1:0] d, input logic [1:0] rs, input logic l);
    r_exp_t e;
    beats_seen++;
    if (r_q.size() == 0) begin
      fail_now($sformatf("r_unexpected_beat_s%0d", n));
    end else begin
      e = r_q.pop_front();
      chk("r_owner", 64'(n), 64'(e.n));
      chk("r_data", 64'(d), 64'(e.data));
      chk("r_resp", 64'(rs), 64'(e.resp));
      chk("r_last", 64'(l), 64'(e.last));
    end
  endfunction

  // Behavioural AXI slave: data = araddr + beat, resp = beat[1:0]
  initial begin : slave
    int st, beat, stall, s_end;
    logic [AW-1:0] s_addr, cap_addr;
    logic [7:0] cap_len;
    bit ar_hs, r_hs;
    st = 0; beat = 0; stall = 0; s_end = 0; s_addr = '0;
    M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0;
    M_AXI_RDATA = '0; M_AXI_RRESP = 2'b00;
    forever begin
      @(negedge CLK);
      ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
      r_hs = M_AXI_RVALID && M_AXI_RREADY;
      cap_addr = M_AXI_ARADDR;
      cap_len = M_AXI_ARLEN;
      @(posedge CLK);
      #1;
      if (!RSTN) begin
        st = 0; stall = 0;
        M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0;
      end else if (st == 0) begin
        M_AXI_RVALID = inject;
        M_AXI_RLAST = 1'b0;
        if (ar_hs) begin
          M_AXI_ARREADY = 1'b0;
          s_addr = cap_addr; beat = 0; stall = 0;
          s_end = (early_last >= 0) ? early_last : int'(cap_len);
          st = 1;
        end else if (M_AXI_ARVALID) begin
          if (stall >= ar_stall) M_AXI_ARREADY = 1'b1;
          else stall++;
        end
      end else if (r_hs) begin
        if (beat == s_end) st = 0;
        else beat++;
      end
      if (RSTN && st == 1) begin
        M_AXI_RVALID = 1'b1;
        M_AXI_RDATA = s_addr + AW'(beat);
        M_AXI_RRESP = 2'(beat);
        M_AXI_RLAST = !omit_last && (beat == s_end);
      end else if (RSTN && st == 0 && !inject) begin
        M_AXI_RVALID = 1'b0;
        M_AXI_RLAST = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every handshake the DUT presents
  initial begin : monitor
    ar_exp_t a;
    forever begin
      @(negedge CLK);
      if (RSTN) begin
        if (M_AXI_ARVALID && M_AXI_ARREADY) begin
          if (ar_q.size() == 0) fail_now("ar_unexpected");
          else begin
            a = ar_q.pop_front();
            chk("ar_grant", 64'(GRANT), 64'(a.n));
            chk("ar_addr", 64'(M_AXI_ARADDR), 64'(a.addr));
            chk("ar_len", 64'(M_AXI_ARLEN), 64'(a.len));
          end
        end
        if (S0_RVALID && S0_RREADY) check_beat(1'b0, S0_RDATA, S0_RRESP, S0_RLAST);
        if (S1_RVALID && S1_RREADY) check_beat(1'b1, S1_RDATA, S1_RRESP, S1_RLAST);
      end
    end
  end

  task automatic push_burst(input bit n, input logic [AW-1:0] addr, input logic [7:0] len,
                            input int last_at, input bit omit);
    ar_exp_t a;
    r_exp_t r;
    int e;
    a.n = n; a.addr = addr; a.len = len;
    ar_q.push_back(a);
    e = (last_at >= 0) ? last_at : int'(len);
    for (int i = 0; i <= e; i++) begin
      r.n = n; r.data = addr + AW'(i); r.resp = 2'(i); r.last = !omit && (i == e);
      r_q.push_back(r);
    end
  endtask

  task automatic raise(input bit n, input logic [AW-1:0] addr, input logic [7:0] len);
    if (n) begin S1_ARADDR = addr; S1_ARLEN = len; S1_ARVALID = 1'b1; end
    else   begin S0_ARADDR = addr; S0_ARLEN = len; S0_ARVALID = 1'b1; end
  endtask

  // Waits for requester n's AR handshake, then drops its ARVALID
  task automatic wait_ar_done(input bit n);
    for (int c = 0; c < 300; c++) begin
      if (n ? (S1_ARVALID && S1_ARREADY) : (S0_ARVALID && S0_ARREADY)) begin
        @(posedge CLK);
        #1;
        if (n) S1_ARVALID = 1'b0; else S0_ARVALID = 1'b0;
        return;
      end
      @(negedge CLK);
    end
    fail_now($sformatf("ar_handshake_timeout_s%0d", n));
  endtask

  task automatic wait_idle(input string name);
    for (int c = 0; c < 1000; c++) begin
      @(negedge CLK);
      if (r_q.size() == 0 && ar_q.size() == 0 && !BUSY) return;
    end
    fail_now(name);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RSTN = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RSTN = 1'b1;
  endtask

  initial begin : stim
    bit found;
    int base;
    RSTN = 1'b0;
    S0_ARADDR = '0; S0_ARLEN = 8'd0; S0_ARVALID = 1'b0; S0_RREADY = 1'b1;
    S1_ARADDR = '0; S1_ARLEN = 8'd0; S1_ARVALID = 1'b0; S1_RREADY = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_arvalid", 64'(M_AXI_ARVALID), 64'd0);
    chk("rst_araddr", 64'(M_AXI_ARADDR), 64'd0);
    chk("rst_arlen", 64'(M_AXI_ARLEN), 64'd0);
    chk("rst_grant", 64'(GRANT), 64'd0);
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_err", 64'(ERR), 64'd0);
    chk("rst_arready", 64'({S0_ARREADY, S1_ARREADY}), 64'd0);
    chk("rst_rvalid_rready", 64'({S0_RVALID, S1_RVALID, M_AXI_RREADY}), 64'd0);
    chk("sideband", 64'({M_AXI_ARID, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARLOCK, M_AXI_ARCACHE,
                          M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARUSER}),
        64'({1'b0, 3'b010, 2'b01, 2'b00, 4'b0011, 3'b000, 4'b0000, 1'b0}));
    RSTN = 1'b1;

    // Single S0 burst of 32 beats; S1 RREADY low so a wrong RREADY mux stalls
    S1_RREADY = 1'b0;
    @(posedge CLK); #1;
    push_burst(1'b0, 32'h1000, 8'h1F, -1, 1'b0);
    raise(1'b0, 32'h1000, 8'h1F);
    @(posedge CLK);
    @(negedge CLK);
    chk("t1_arvalid_next", 64'(M_AXI_ARVALID), 64'd1);
    chk("t1_araddr_next", 64'(M_AXI_ARADDR), 64'h1000);
    chk("t1_grant", 64'(GRANT), 64'd0);
    chk("t1_busy", 64'(BUSY), 64'd1);
    wait_ar_done(1'b0);
    wait_idle("t1_burst_timeout");
    chk("t1_err", 64'(ERR), 64'd0);
    S1_RREADY = 1'b1;

    // Simultaneous requests after reset: S0 first, S1 after one IDLE cycle
    do_reset();
    @(posedge CLK); #1;
    push_burst(1'b0, 32'h1100, 8'd3, -1, 1'b0);
    push_burst(1'b1, 32'h2000, 8'd3, -1, 1'b0);
    raise(1'b0, 32'h1100, 8'd3);
    raise(1'b1, 32'h2000, 8'd3);
    wait_ar_done(1'b0);
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge CLK);
      if (S0_RVALID && S0_RREADY && S0_RLAST) found = 1'b1;
    end
    chk("t2_s0_last_seen", 64'(found), 64'd1);
    @(negedge CLK);
    chk("t2_idle_gap_busy", 64'(BUSY), 64'd0);
    chk("t2_idle_gap_arvalid", 64'(M_AXI_ARVALID), 64'd0);
    @(negedge CLK);
    chk("t2_s1_grant", 64'(GRANT), 64'd1);
    chk("t2_s1_arvalid", 64'(M_AXI_ARVALID), 64'd1);
    chk("t2_s1_araddr", 64'(M_AXI_ARADDR), 64'h2000);
    wait_ar_done(1'b1);
    wait_idle("t2_burst_timeout");

    // Continuous requests from both: grants alternate 0,1,0,1
    @(posedge CLK); #1;
    push_burst(1'b0, 32'h3000, 8'd1, -1, 1'b0);
    push_burst(1'b1, 32'h4000, 8'd1, -1, 1'b0);
    push_burst(1'b0, 32'h3100, 8'd1, -1, 1'b0);
    push_burst(1'b1, 32'h4100, 8'd1, -1, 1'b0);
    raise(1'b0, 32'h3000, 8'd1);
    raise(1'b1, 32'h4000, 8'd1);
    wait_ar_done(1'b0);
    raise(1'b0, 32'h3100, 8'd1);
    wait_ar_done(1'b1);
    raise(1'b1, 32'h4100, 8'd1);
    wait_ar_done(1'b0);
    wait_ar_done(1'b1);
    wait_idle("t3_burst_timeout");

    // ARREADY held low 5 cycles: AR payload stable, no ARREADY to requester
    ar_stall = 5;
    @(posedge CLK); #1;
    push_burst(1'b1, 32'h5000, 8'd2, -1, 1'b0);
    raise(1'b1, 32'h5000, 8'd2);
    for (int k = 0; k < 5; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      chk("t4_arvalid_held", 64'(M_AXI_ARVALID), 64'd1);
      chk("t4_araddr_stable", 64'(M_AXI_ARADDR), 64'h5000);
      chk("t4_arlen_stable", 64'(M_AXI_ARLEN), 64'd2);
      chk("t4_s1_arready_low", 64'(S1_ARREADY), 64'd0);
    end
    wait_ar_done(1'b1);
    ar_stall = 0;
    wait_idle("t4_burst_timeout");

    // Early RLAST on beat 16 of a 32-beat burst: ERR, back to IDLE, sticky
    early_last = 16;
    @(posedge CLK); #1;
    push_burst(1'b0, 32'h6000, 8'h1F, 16, 1'b0);
    raise(1'b0, 32'h6000, 8'h1F);
    wait_ar_done(1'b0);
    wait_idle("t5_burst_timeout");
    early_last = -1;
    chk("t5_err_early_last", 64'(ERR), 64'd1);
    chk("t5_idle", 64'(BUSY), 64'd0);
    @(posedge CLK); #1;
    push_burst(1'b1, 32'h7000, 8'd3, -1, 1'b0);
    raise(1'b1, 32'h7000, 8'd3);
    wait_ar_done(1'b1);
    wait_idle("t5_clean_timeout");
    chk("t5_err_sticky", 64'(ERR), 64'd1);

    // Reset at beat 10 of a burst: immediate reset values, then S1 served
    @(posedge CLK); #1;
    push_burst(1'b0, 32'h8000, 8'h1F, -1, 1'b0);
    base = beats_seen;
    raise(1'b0, 32'h8000, 8'h1F);
    wait_ar_done(1'b0);
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge CLK);
      if (beats_seen >= base + 10) found = 1'b1;
    end
    chk("t6_beat10_reached", 64'(found), 64'd1);
    #1;
    RSTN = 1'b0;
    #1;
    r_q.delete();
    ar_q.delete();
    chk("t6_rst_arvalid", 64'(M_AXI_ARVALID), 64'd0);
    chk("t6_rst_busy", 64'(BUSY), 64'd0);
    chk("t6_rst_err", 64'(ERR), 64'd0);
    chk("t6_rst_grant", 64'(GRANT), 64'd0);
    chk("t6_rst_ar", 64'({M_AXI_ARADDR, M_AXI_ARLEN}), 64'd0);
    chk("t6_rst_r", 64'({S0_RVALID, S1_RVALID, M_AXI_RREADY}), 64'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RSTN = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    push_burst(1'b1, 32'h2000, 8'd3, -1, 1'b0);
    raise(1'b1, 32'h2000, 8'd3);
    wait_ar_done(1'b1);
    wait_idle("t6_burst_timeout");
    chk("t6_err_clean", 64'(ERR), 64'd0);

    // RVALID while idle: flagged, never forwarded
    @(posedge CLK); #1;
    inject = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    inject = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("t7_err_stray_rvalid", 64'(ERR), 64'd1);
    chk("t7_idle", 64'(BUSY), 64'd0);

    // Beat count reaches ARLEN+1 with no RLAST: ERR and return to IDLE
    do_reset();
    chk("t8_err_after_reset", 64'(ERR), 64'd0);
    omit_last = 1'b1;
    @(posedge CLK); #1;
    push_burst(1'b1, 32'h9000, 8'd3, -1, 1'b1);
    raise(1'b1, 32'h9000, 8'd3);
    wait_ar_done(1'b1);
    wait_idle("t8_burst_timeout");
    omit_last = 1'b0;
    chk("t8_err_no_last", 64'(ERR), 64'd1);
    chk("t8_idle", 64'(BUSY), 64'd0);

    repeat (3) @(posedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
